// File: rtl/video_fetch.sv
// video_fetch: requester side of the memory controller's video read port.
// For every 8-pixel cell it reads the bitmap byte and then the attribute
// byte from the screen page, buffers both in a pending stage, and hands them
// to the pixel shifter on its load strobe. Reads that never get an ack are
// abandoned after ACK_TIMEOUT cycles and flagged through the sticky underrun.
module video_fetch #(
    parameter int         ACK_TIMEOUT     = 16,
    parameter logic [7:0] UNDERRUN_BITMAP = 8'h00
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        i_fetch_start,
    input  logic [4:0]  i_col,
    input  logic [7:0]  i_row,
    output logic        o_video_read_req,
    output logic [14:0] o_video_read_addr,
    input  logic        i_video_read_req_ack,
    input  logic        i_video_data_valid,
    input  logic [7:0]  i_vd,
    input  logic        i_cell_load,
    output logic [7:0]  o_bitmap_out,
    output logic [7:0]  o_attr_out,
    output logic        o_underrun,
    output logic        o_busy
);

    localparam int            CW       = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 2;
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_BM  = 3'd1,
        S_WAIT_BM = 3'd2,
        S_REQ_AT  = 3'd3,
        S_WAIT_AT = 3'd4
    } state_t;

    // Screen-page bitmap address: thirds, pixel line in char, char row, column.
    function automatic logic [14:0] f_bm_addr(input logic [4:0] x, input logic [7:0] y);
        return {2'b10, y[7:6], y[2:0], y[5:3], x};
    endfunction

    // Attribute address: one byte per 8x8 character cell.
    function automatic logic [14:0] f_at_addr(input logic [4:0] x, input logic [7:0] y);
        return {5'b10110, y[7:3], x};
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_col;
    logic [7:0]     r_row;
    logic [CW-1:0]  r_tmo_cnt;
    logic [7:0]     r_pend_bm;
    logic [7:0]     r_pend_at;
    logic           r_pend_valid;
    logic           r_req;
    logic [14:0]    r_addr;
    logic [7:0]     r_bitmap;
    logic [7:0]     r_attr;
    logic           r_underrun;
    logic           r_busy;

    logic           w_start;
    logic           w_timeout;
    logic           w_bm_cap;
    logic           w_at_cap;
    logic           w_req_entry;
    logic [4:0]     w_x;
    logic [7:0]     w_y;

    // The position is taken straight from the inputs on the start cycle so the
    // first address is valid together with the first request.
    assign w_start     = (r_state == S_IDLE) && i_fetch_start;
    assign w_x         = w_start ? i_col : r_col;
    assign w_y         = w_start ? i_row : r_row;
    assign w_req_entry = ((w_next == S_REQ_BM) && (r_state != S_REQ_BM)) ||
                         ((w_next == S_REQ_AT) && (r_state != S_REQ_AT));

    // Next-state decode; data_valid only counts in WAIT states, i.e. after the ack.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_bm_cap  = 1'b0;
        w_at_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_fetch_start) w_next = S_REQ_BM;
                else               w_next = S_IDLE;
            end
            S_REQ_BM: begin
                if (i_video_read_req_ack) begin
                    w_next = S_WAIT_BM;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = S_REQ_BM;
                end
            end
            S_WAIT_BM: begin
                if (i_video_data_valid) begin
                    w_next   = S_REQ_AT;
                    w_bm_cap = 1'b1;
                end else begin
                    w_next = S_WAIT_BM;
                end
            end
            S_REQ_AT: begin
                if (i_video_read_req_ack) begin
                    w_next = S_WAIT_AT;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = S_REQ_AT;
                end
            end
            S_WAIT_AT: begin
                if (i_video_data_valid) begin
                    w_next   = S_IDLE;
                    w_at_cap = 1'b1;
                end else begin
                    w_next = S_WAIT_AT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Latch the cell position and run the ack timeout counter.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= 5'd0;
            r_row     <= 8'd0;
            r_tmo_cnt <= {CW{1'b0}};
        end else begin
            if (w_start) begin
                r_col <= i_col;
                r_row <= i_row;
            end
            if (w_req_entry)
                r_tmo_cnt <= {CW{1'b0}};
            else if ((r_state == S_REQ_BM) || (r_state == S_REQ_AT))
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end

    // Registered request, address and busy, decoded from the next state so they
    // line up with the state they belong to. Address holds while idle or in WAIT_AT.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= 1'b0;
            r_addr <= 15'd0;
            r_busy <= 1'b0;
        end else begin
            r_req  <= (w_next == S_REQ_BM) || (w_next == S_WAIT_BM) || (w_next == S_REQ_AT);
            r_busy <= (w_next != S_IDLE);
            case (w_next)
                S_REQ_BM:            r_addr <= f_bm_addr(w_x, w_y);
                S_WAIT_BM, S_REQ_AT: r_addr <= f_at_addr(w_x, w_y);
                default:             r_addr <= r_addr;
            endcase
        end
    end

    // Pending stage: both bytes of the cell in flight; completion wins over a
    // simultaneous load so the fresh cell waits for the next strobe.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_bm    <= 8'd0;
            r_pend_at    <= 8'd0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_bm_cap) r_pend_bm <= i_vd;
            if (w_at_cap) r_pend_at <= i_vd;
            if (w_at_cap)
                r_pend_valid <= 1'b1;
            else if (w_start || i_cell_load)
                r_pend_valid <= 1'b0;
        end
    end

    // Output registers toward the shifter plus the sticky underrun flag.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap   <= 8'd0;
            r_attr     <= 8'd0;
            r_underrun <= 1'b0;
        end else begin
            if (i_cell_load) begin
                if (r_pend_valid) begin
                    r_bitmap <= r_pend_bm;
                    r_attr   <= r_pend_at;
                end else begin
                    r_bitmap <= UNDERRUN_BITMAP;
                end
            end
            if (w_timeout || (i_cell_load && !r_pend_valid))
                r_underrun <= 1'b1;
        end
    end

    assign o_video_read_req  = r_req;
    assign o_video_read_addr = r_addr;
    assign o_bitmap_out      = r_bitmap;
    assign o_attr_out        = r_attr;
    assign o_underrun        = r_underrun;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: scoreboard bench for video_fetch. A behavioural memory
// controller serves reads from a video RAM array; expected addresses and
// expected shifter outputs are queued by the stimulus and popped by monitors.
module tb_video_fetch;

    localparam int         ACK_TIMEOUT = 16;
    localparam logic [7:0] UNDER_BM    = 8'h00;

    logic        clk28;
    logic        rst_n;
    logic        fetch_start;
    logic [4:0]  col;
    logic [7:0]  row;
    logic        o_req;
    logic [14:0] o_addr;
    logic        ack;
    logic        valid;
    logic [7:0]  vd;
    logic        load_stim;
    logic        load_ctrl;
    wire         cell_load = load_stim | load_ctrl;
    logic [7:0]  o_bm;
    logic [7:0]  o_at;
    logic        o_und;
    logic        o_busy;

    video_fetch #(.ACK_TIMEOUT(ACK_TIMEOUT), .UNDERRUN_BITMAP(UNDER_BM)) dut (
        .clk28               (clk28),
        .rst_n               (rst_n),
        .i_fetch_start       (fetch_start),
        .i_col               (col),
        .i_row               (row),
        .o_video_read_req    (o_req),
        .o_video_read_addr   (o_addr),
        .i_video_read_req_ack(ack),
        .i_video_data_valid  (valid),
        .i_vd                (vd),
        .i_cell_load         (cell_load),
        .o_bitmap_out        (o_bm),
        .o_attr_out          (o_at),
        .o_underrun          (o_und),
        .o_busy              (o_busy)
    );

    initial begin
        clk28 = 1'b0;
        forever #5 clk28 = ~clk28;
    end

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  vmem [0:32767];
    logic [14:0] exp_addr_q[$];
    logic [16:0] out_q[$];

    // controller configuration (written by stimulus only)
    int cfg_ack_dly   = 0;
    int cfg_valid_dly = 0;
    bit cfg_stale     = 1'b0;
    bit cfg_noack     = 1'b0;
    bit cfg_collide   = 1'b0;
    int unstable      = 0;

    // reference model state
    bit         m_pv  = 1'b0;
    logic [7:0] m_pbm = 8'h00;
    logic [7:0] m_pat = 8'h00;
    logic [7:0] m_bm  = 8'h00;
    logic [7:0] m_at  = 8'h00;
    bit         m_und = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Screen layout arithmetic: thirds of 2 KB, 256 B per pixel line, 32 B per char row.
    function automatic logic [14:0] ref_bm(input int c, input int r);
        return 15'(16'h4000 + (r / 64) * 2048 + (r % 8) * 256 + ((r / 8) % 8) * 32 + c);
    endfunction

    function automatic logic [14:0] ref_at(input int c, input int r);
        return 15'(16'h5800 + (r / 8) * 32 + c);
    endfunction

    // Behavioural memory controller, acting on falling edges.
    initial begin : ctrl
        bit          c_serving;
        bit          c_phase;
        int          c_cnt;
        logic [14:0] c_addr;
        c_serving = 1'b0; c_phase = 1'b0; c_cnt = 0; c_addr = 15'd0;
        ack = 1'b0; valid = 1'b0; vd = 8'h00; load_ctrl = 1'b0;
        forever begin
            @(negedge clk28);
            ack = 1'b0; valid = 1'b0; load_ctrl = 1'b0; vd = 8'($urandom);
            if (!rst_n) begin
                c_serving = 1'b0;
            end else if (!c_serving) begin
                if (o_req) begin
                    c_serving = 1'b1; c_phase = 1'b0; c_cnt = cfg_ack_dly; c_addr = o_addr;
                end
            end else if (!c_phase) begin
                if (!o_req) begin
                    c_serving = 1'b0;
                end else begin
                    if (o_addr != c_addr) unstable++;
                    if (c_cnt == 0 && !cfg_noack) begin
                        ack = 1'b1;
                        if (exp_addr_q.size() == 0) chk("unexpected_read", 32'(o_addr), 32'h0);
                        else chk("read_addr", 32'(o_addr), 32'(exp_addr_q.pop_front()));
                        c_phase = 1'b1; c_cnt = cfg_valid_dly;
                    end else begin
                        if (c_cnt != 0) c_cnt--;
                        if (cfg_stale) begin valid = 1'b1; vd = 8'hFF; end
                    end
                end
            end else begin
                if (c_cnt == 0) begin
                    valid = 1'b1; vd = vmem[c_addr]; c_serving = 1'b0;
                    if (cfg_collide && c_addr >= 15'h5800) load_ctrl = 1'b1;
                end else begin
                    c_cnt--;
                end
            end
        end
    end

    // Output monitor: after every accepted cell_load compare against the queue.
    initial begin : mon
        logic [16:0] e;
        forever begin
            @(posedge clk28);
            if (cell_load && rst_n) begin
                @(negedge clk28);
                if (out_q.size() == 0) begin
                    chk("unexpected_load", 32'(o_bm), 32'hFFFF);
                end else begin
                    e = out_q.pop_front();
                    chk("bitmap_out", 32'(o_bm), 32'(e[16:9]));
                    chk("attr_out", 32'(o_at), 32'(e[8:1]));
                    chk("underrun", 32'(o_und), 32'(e[0]));
                end
            end
        end
    end

    task automatic do_cell(input int c, input int r, input int ad, input int vdl,
                           input bit st, input bit na, input bit coll,
                           output int lat, output int reqc);
        @(negedge clk28);
        cfg_ack_dly = ad; cfg_valid_dly = vdl; cfg_stale = st; cfg_noack = na; cfg_collide = coll;
        col = 5'(c); row = 8'(r); fetch_start = 1'b1;
        m_pv = 1'b0;
        if (!na) begin
            exp_addr_q.push_back(ref_bm(c, r));
            exp_addr_q.push_back(ref_at(c, r));
        end
        if (coll) begin
            m_bm = UNDER_BM; m_und = 1'b1;
            out_q.push_back({m_bm, m_at, m_und});
        end
        @(negedge clk28);
        fetch_start = 1'b0;
        lat = 1; reqc = 0;
        while (o_busy && lat < 300) begin
            if (o_req) reqc++;
            @(negedge clk28);
            lat++;
        end
        if (lat >= 300) chk("fetch_done_timeout", 32'(lat), 32'd0);
        if (!na) begin
            m_pv = 1'b1; m_pbm = vmem[ref_bm(c, r)]; m_pat = vmem[ref_at(c, r)];
        end else begin
            m_und = 1'b1;
        end
        cfg_collide = 1'b0; cfg_noack = 1'b0; cfg_stale = 1'b0;
    endtask

    task automatic do_load();
        @(negedge clk28);
        load_stim = 1'b1;
        if (m_pv) begin
            m_bm = m_pbm; m_at = m_pat; m_pv = 1'b0;
        end else begin
            m_bm = UNDER_BM; m_und = 1'b1;
        end
        out_q.push_back({m_bm, m_at, m_und});
        @(negedge clk28);
        load_stim = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, reqc, snap, k, sel;
        rst_n = 1'b0; fetch_start = 1'b0; col = 5'd0; row = 8'd0; load_stim = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            vmem[i] = 8'($urandom);
            if (vmem[i] == 8'hFF) vmem[i] = 8'hFE;
        end
        vmem[15'h4000] = 8'hAA;
        vmem[15'h5800] = 8'h47;
        repeat (3) @(negedge clk28);
        chk("reset_outputs", 32'({o_req, o_addr, o_bm, o_at, o_und, o_busy}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk28);

        // ideal controller, first cell with known data and latency bound
        do_cell(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, lat, reqc);
        chk("latency_le_8", 32'(lat <= 8), 32'd1);
        do_load();

        // corner positions
        do_cell(31, 191, 0, 0, 1'b0, 1'b0, 1'b0, lat, reqc);
        do_load();
        do_cell(3, 65, 1, 1, 1'b0, 1'b0, 1'b0, lat, reqc);
        do_load();

        // ack held off 10 cycles: request must stay put
        snap = unstable;
        do_cell(5, 100, 10, 2, 1'b0, 1'b0, 1'b0, lat, reqc);
        chk("req_stable", 32'(unstable), 32'(snap));
        chk("no_underrun_holdoff", 32'(o_und), 32'd0);
        do_load();

        // stale valid with 0xFF before each ack, real 0x3C afterwards
        vmem[ref_bm(7, 20)] = 8'h3C;
        do_cell(7, 20, 3, 0, 1'b1, 1'b0, 1'b0, lat, reqc);
        do_load();

        // no ack at all: abandoned after ACK_TIMEOUT cycles
        do_cell(2, 2, 0, 0, 1'b0, 1'b1, 1'b0, lat, reqc);
        chk("timeout_req_cycles", 32'(reqc), 32'(ACK_TIMEOUT));
        chk("timeout_underrun", 32'(o_und), 32'd1);
        chk("timeout_idle", 32'({o_busy, o_req}), 32'd0);
        do_load();

        // load coincides with attribute completion: new cell stays pending
        do_cell(9, 9, 0, 0, 1'b0, 1'b0, 1'b1, lat, reqc);
        do_load();

        // asynchronous reset while waiting for attribute data
        @(negedge clk28);
        cfg_ack_dly = 0; cfg_valid_dly = 6;
        col = 5'd12; row = 8'd77; fetch_start = 1'b1; m_pv = 1'b0;
        exp_addr_q.push_back(ref_bm(12, 77));
        exp_addr_q.push_back(ref_at(12, 77));
        @(negedge clk28);
        fetch_start = 1'b0;
        k = 0;
        while (!(o_busy && !o_req) && k < 100) begin @(negedge clk28); k++; end
        chk("reached_wait_at", 32'(k < 100), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("reset_in_wait_at", 32'({o_req, o_addr, o_bm, o_at, o_und, o_busy}), 32'h0);
        m_pv = 1'b0; m_bm = 8'h00; m_at = 8'h00; m_und = 1'b0;
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        do_cell(20, 150, 0, 0, 1'b0, 1'b0, 1'b0, lat, reqc);
        do_load();

        // randomized cells, delays and load patterns
        for (int i = 0; i < 25; i++) begin
            do_cell($urandom_range(0, 31), $urandom_range(0, 191), $urandom_range(0, 6),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0, lat, reqc);
            sel = $urandom_range(0, 5);
            if (sel == 1) begin
                do_load();
                do_load();
            end else if (sel != 0) begin
                do_load();
            end
        end

        repeat (4) @(negedge clk28);
        chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("out_queue_empty", 32'(out_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
